// File: rtl/cpu_pkg.sv
// Shared definitions for the single-issue core.
// Sequencer states, opcodes and default load wait.
package cpu_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'b00,
    SEQ_FETCH   = 2'b01,
    SEQ_EXECUTE = 2'b10,
    SEQ_STALL   = 2'b11
  } seq_state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int DEFAULT_LOAD_WAIT = 1;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/strobe bundle between host, control_unit,
// datapath and the sequencer.
interface cpu_sequencer_if #(
  parameter int RETIRE_WIDTH = 16
);
  logic                    processor_enable;
  logic                    memory_to_register;
  logic                    memory_write_in;
  logic                    register_write_in;
  logic                    instruction_load;
  logic                    pc_write;
  logic                    register_write;
  logic                    memory_write;
  logic [1:0]              state;
  logic [RETIRE_WIDTH-1:0] retired_count;

  modport master (
    output processor_enable,
    output memory_to_register,
    output memory_write_in,
    output register_write_in,
    input  instruction_load,
    input  pc_write,
    input  register_write,
    input  memory_write,
    input  state,
    input  retired_count
  );

  modport slave (
    input  processor_enable,
    input  memory_to_register,
    input  memory_write_in,
    input  register_write_in,
    output instruction_load,
    output pc_write,
    output register_write,
    output memory_write,
    output state,
    output retired_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXECUTE/STALL sequencer.
// Gates PC, IR, regfile and dmem write strobes.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int LOAD_WAIT_CYCLES = DEFAULT_LOAD_WAIT,
  parameter int RETIRE_WIDTH     = 16
) (
  input  logic             clock,
  input  logic             reset,
  cpu_sequencer_if.slave   bus
);

  seq_state_e              state_q, state_d;
  logic [1:0]              stall_q, stall_d;
  logic [RETIRE_WIDTH-1:0] count_q;
  logic                    retire;
  logic                    il, pw, rw, mw;
  logic                    en, ld;

  assign en = bus.processor_enable;
  assign ld = bus.memory_to_register;

  // State, stall counter and retire counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SEQ_IDLE;
      stall_q <= 2'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  // Next state and strobes; a started instruction always retires
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    il      = 1'b0;
    pw      = 1'b0;
    rw      = 1'b0;
    mw      = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (en) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        il      = en;
        state_d = en ? SEQ_EXECUTE : SEQ_IDLE;
      end
      SEQ_EXECUTE: begin
        mw = bus.memory_write_in & ~ld;
        if (ld && LOAD_WAIT_CYCLES > 0) begin
          stall_d = 2'(LOAD_WAIT_CYCLES - 1);
          state_d = SEQ_STALL;
        end else begin
          pw      = 1'b1;
          rw      = bus.register_write_in;
          retire  = 1'b1;
          state_d = en ? SEQ_FETCH : SEQ_IDLE;
        end
      end
      SEQ_STALL: begin
        if (stall_q != 2'd0) begin
          stall_d = stall_q - 2'd1;
        end else begin
          pw      = 1'b1;
          rw      = bus.register_write_in;
          retire  = 1'b1;
          state_d = en ? SEQ_FETCH : SEQ_IDLE;
        end
      end
    endcase
  end

  assign bus.instruction_load = reset & il;
  assign bus.pc_write         = reset & pw;
  assign bus.register_write   = reset & rw;
  assign bus.memory_write     = reset & mw;
  assign bus.state            = state_q;
  assign bus.retired_count    = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: vector table, corner
// sequences and a random run against an instruction model.
module tb_cpu_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        en[3], mtr[3], mwi[3], rwi[3];
  logic [1:0]  st[3];
  logic        il[3], pw[3], rw[3], mw[3];
  logic [15:0] cnt[3];

  localparam int WAITS[3] = '{1, 2, 0};
  localparam int WIDS[3]  = '{16, 4, 8};

  cpu_sequencer_if #(.RETIRE_WIDTH(16)) b0 ();
  cpu_sequencer_if #(.RETIRE_WIDTH(4))  b1 ();
  cpu_sequencer_if #(.RETIRE_WIDTH(8))  b2 ();

  cpu_sequencer #(.LOAD_WAIT_CYCLES(1), .RETIRE_WIDTH(16)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave));
  cpu_sequencer #(.LOAD_WAIT_CYCLES(2), .RETIRE_WIDTH(4)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave));
  cpu_sequencer #(.LOAD_WAIT_CYCLES(0), .RETIRE_WIDTH(8)) dut2 (
    .clock(clock), .reset(reset), .bus(b2.slave));

  assign b0.processor_enable   = en[0];
  assign b0.memory_to_register = mtr[0];
  assign b0.memory_write_in    = mwi[0];
  assign b0.register_write_in  = rwi[0];
  assign st[0]  = b0.state;
  assign il[0]  = b0.instruction_load;
  assign pw[0]  = b0.pc_write;
  assign rw[0]  = b0.register_write;
  assign mw[0]  = b0.memory_write;
  assign cnt[0] = b0.retired_count;

  assign b1.processor_enable   = en[1];
  assign b1.memory_to_register = mtr[1];
  assign b1.memory_write_in    = mwi[1];
  assign b1.register_write_in  = rwi[1];
  assign st[1]  = b1.state;
  assign il[1]  = b1.instruction_load;
  assign pw[1]  = b1.pc_write;
  assign rw[1]  = b1.register_write;
  assign mw[1]  = b1.memory_write;
  assign cnt[1] = {12'd0, b1.retired_count};

  assign b2.processor_enable   = en[2];
  assign b2.memory_to_register = mtr[2];
  assign b2.memory_write_in    = mwi[2];
  assign b2.register_write_in  = rwi[2];
  assign st[2]  = b2.state;
  assign il[2]  = b2.instruction_load;
  assign pw[2]  = b2.pc_write;
  assign rw[2]  = b2.register_write;
  assign mw[2]  = b2.memory_write;
  assign cnt[2] = {8'd0, b2.retired_count};

  typedef struct {
    bit [3:0]  in;
    bit [1:0]  st;
    bit [3:0]  o;
    bit [15:0] c;
  } vec_t;

  function automatic vec_t v(bit [3:0] i, bit [1:0] s,
                             bit [3:0] o, int c);
    vec_t r;
    r.in = i;
    r.st = s;
    r.o  = o;
    r.c  = 16'(c);
    return r;
  endfunction

  function automatic logic [31:0] pk(bit [1:0] s,
                                     bit [3:0] o, int c);
    return {10'd0, s, o, 16'(c)};
  endfunction

  function automatic logic [31:0] obs(int d);
    return {10'd0, st[d], il[d], pw[d], rw[d], mw[d], cnt[d]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(int d, bit [3:0] i);
    en[d]  = i[3];
    mtr[d] = i[2];
    mwi[d] = i[1];
    rwi[d] = i[0];
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  vec_t tbl[20];

  // Random-phase model: position within current instruction
  bit act[3];
  int pos[3];
  int mcnt[3];

  initial begin
    bit ok;
    for (int d = 0; d < 3; d++) drive(d, 4'b0000);

    // in = {en, mtr, mwi, rwi}; o = {il, pw, rw, mw}
    tbl[0]  = v(4'b1001, 2'd0, 4'b0000, 0);
    tbl[1]  = v(4'b1001, 2'd1, 4'b1000, 0);
    tbl[2]  = v(4'b1001, 2'd2, 4'b0110, 0);
    tbl[3]  = v(4'b1001, 2'd1, 4'b1000, 1);
    tbl[4]  = v(4'b1001, 2'd2, 4'b0110, 1);
    tbl[5]  = v(4'b1101, 2'd1, 4'b1000, 2);
    tbl[6]  = v(4'b1101, 2'd2, 4'b0000, 2);
    tbl[7]  = v(4'b1101, 2'd3, 4'b0110, 2);
    tbl[8]  = v(4'b1010, 2'd1, 4'b1000, 3);
    tbl[9]  = v(4'b1010, 2'd2, 4'b0101, 3);
    tbl[10] = v(4'b1110, 2'd1, 4'b1000, 4);
    tbl[11] = v(4'b1110, 2'd2, 4'b0000, 4);
    tbl[12] = v(4'b1110, 2'd3, 4'b0100, 4);
    tbl[13] = v(4'b1101, 2'd1, 4'b1000, 5);
    tbl[14] = v(4'b1101, 2'd2, 4'b0000, 5);
    tbl[15] = v(4'b0101, 2'd3, 4'b0110, 5);
    tbl[16] = v(4'b0101, 2'd0, 4'b0000, 6);
    tbl[17] = v(4'b1001, 2'd0, 4'b0000, 6);
    tbl[18] = v(4'b0001, 2'd1, 4'b0000, 6);
    tbl[19] = v(4'b0001, 2'd0, 4'b0000, 6);

    // Reset held with enable high
    drive(0, 4'b1001);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_hold", obs(0), pk(0, 4'b0000, 0));

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clock);
      drive(0, tbl[i].in);
      #1;
      chk($sformatf("vec%0d", i), obs(0),
          pk(tbl[i].st, tbl[i].o, tbl[i].c));
    end

    // Reset asserted mid-EXECUTE of a store
    @(negedge clock);
    drive(0, 4'b1010);
    ok = 1'b0;
    for (int k = 0; k < 6 && !ok; k++) begin
      step();
      if (st[0] == 2'd2) ok = 1'b1;
    end
    chk("store_reached_exec", 32'(ok), 32'd1);
    chk("store_strobe", 32'(mw[0]), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_store", obs(0), pk(0, 4'b0000, 0));
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("release_idle", obs(0), pk(0, 4'b0000, 0));
    step();
    chk("release_fetch", obs(0), pk(1, 4'b1000, 0));
    drive(0, 4'b0000);

    // Zero-wait load, also an illegal load+store decode
    drive(2, 4'b1111);
    #1;
    chk("w0_idle", obs(2), pk(0, 4'b0000, 0));
    step();
    chk("w0_fetch", obs(2), pk(1, 4'b1000, 0));
    step();
    chk("w0_exec", obs(2), pk(2, 4'b0110, 0));
    @(negedge clock);
    drive(2, 4'b0111);
    #1;
    chk("w0_abort", obs(2), pk(1, 4'b0000, 1));
    step();
    chk("w0_idle2", obs(2), pk(0, 4'b0000, 1));

    // Two-wait load then wrap of a 4-bit counter
    drive(1, 4'b1101);
    #1;
    chk("w2_idle", obs(1), pk(0, 4'b0000, 0));
    step();
    chk("w2_fetch", obs(1), pk(1, 4'b1000, 0));
    step();
    chk("w2_exec", obs(1), pk(2, 4'b0000, 0));
    step();
    chk("w2_stall0", obs(1), pk(3, 4'b0000, 0));
    step();
    chk("w2_stall1", obs(1), pk(3, 4'b0110, 0));
    @(negedge clock);
    drive(1, 4'b1001);
    #1;
    chk("w2_next", obs(1), pk(1, 4'b1000, 1));
    repeat (28) @(negedge clock);
    #1;
    chk("wrap_pre", obs(1), pk(1, 4'b1000, 15));
    repeat (2) @(negedge clock);
    #1;
    chk("wrap_zero", obs(1), pk(1, 4'b1000, 0));
    drive(1, 4'b0000);

    // Random run on all three against the instruction model
    @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      act[d]  = 1'b0;
      pos[d]  = 0;
      mcnt[d] = 0;
    end
    @(negedge clock);
    reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        if (!act[d] || pos[d] == 0) begin
          int r;
          r = int'($urandom_range(0, 9));
          mtr[d] = (r == 4 || r == 5 || r == 8);
          mwi[d] = (r == 6 || r == 7 || r == 8);
          rwi[d] = (r < 4) || (r == 4) ||
                   (r == 5 && $urandom_range(0, 1) == 1);
        end
        en[d] = ($urandom_range(0, 15) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        bit [1:0] es;
        bit [3:0] eo;
        int       len;
        bit       last;
        es = 2'd0;
        eo = 4'b0000;
        if (!act[d]) begin
          es = 2'd0;
          chk($sformatf("rnd%0d_%0d", d, cyc), obs(d),
              pk(es, eo, mcnt[d]));
          act[d] = en[d];
          pos[d] = 0;
        end else if (pos[d] == 0) begin
          es = 2'd1;
          eo[3] = en[d];
          chk($sformatf("rnd%0d_%0d", d, cyc), obs(d),
              pk(es, eo, mcnt[d]));
          if (en[d]) pos[d] = 1;
          else act[d] = 1'b0;
        end else begin
          len  = 2 + (mtr[d] ? WAITS[d] : 0);
          last = (pos[d] == len - 1);
          es   = (pos[d] == 1) ? 2'd2 : 2'd3;
          eo[2] = last;
          eo[1] = last & rwi[d];
          eo[0] = (pos[d] == 1) & mwi[d] & ~mtr[d];
          chk($sformatf("rnd%0d_%0d", d, cyc), obs(d),
              pk(es, eo, mcnt[d]));
          if (last) begin
            mcnt[d] = (mcnt[d] + 1) % (1 << WIDS[d]);
            if (en[d]) pos[d] = 0;
            else act[d] = 1'b0;
          end else begin
            pos[d] = pos[d] + 1;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle sequencer for the single-issue processor core. It steps each instruction through FETCH, EXECUTE and an optional load STALL.
- Generates the PC and instruction-register write strobes.
- Gates the register-file and data-memory write enables that control_unit decodes, so each write happens exactly once per instruction.
- Sits between control_unit and the datapath. The host run/stop bit drives it through processor_enable.

Parameters:
LOAD_WAIT_CYCLES, 1, extra cycles a load waits for synchronous data-memory read data (0..3)
RETIRE_WIDTH, 16, width of the retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
processor_enable  input  1  host run request; 1 = execute instructions
memory_to_register  input  1  from control_unit: current instruction is a load
memory_write_in  input  1  from control_unit: current instruction is a store
register_write_in  input  1  from control_unit: current instruction writes the register file
instruction_load  output  1  instruction register captures instruction memory data at the clock edge ending this cycle
pc_write  output  1  PC updates (PC+4, branch or jump target) at the edge ending this cycle
register_write  output  1  gated register-file write enable
memory_write  output  1  gated data-memory write enable
state  output  2  current state, for debug/host readback
retired_count  output  RETIRE_WIDTH  number of instructions retired since reset

Behaviour:
- State register encodings: IDLE=00, FETCH=01, EXECUTE=10, STALL=11.
- State register, stall counter and retired_count reset asynchronously when reset=0, to IDLE, 0 and 0 respectively.
- All other outputs are combinational from state, the stall counter and the inputs; they are 0 while reset=0.
- IDLE: all strobes 0. If processor_enable=1, go to FETCH next edge; otherwise stay in IDLE.
- FETCH:
  - processor_enable=1: instruction_load=1, next state EXECUTE.
  - processor_enable=0: instruction_load=0, next state IDLE. Nothing is retired and the PC is unchanged.
- EXECUTE, control_unit outputs valid:
  - Store (memory_write_in=1): memory_write=1 for exactly this cycle.
  - Load (memory_to_register=1) with LOAD_WAIT_CYCLES>0: pc_write=0 and register_write=0; load the stall counter with LOAD_WAIT_CYCLES-1; next state STALL.
  - All other cases: pc_write=1, register_write=register_write_in, retired_count+1; next state FETCH if processor_enable=1, else IDLE.
- STALL:
  - memory_write=0 throughout.
  - Counter non-zero: decrement it; pc_write=0, register_write=0.
  - Counter zero: pc_write=1, register_write=register_write_in, retired_count+1; next state FETCH if processor_enable=1, else IDLE.
  - Load latency is therefore 2+LOAD_WAIT_CYCLES cycles; every other instruction takes 2 cycles.
- Enable drop mid-instruction: once past FETCH, the instruction always completes and retires before IDLE is entered. Only FETCH aborts.
- memory_to_register and memory_write_in both 1 (illegal decode): treat as a load; memory_write stays 0.
- retired_count wraps from all-ones to 0 with no flag.
- Async reset mid-instruction: all strobes drop immediately with no partial retirement. After release, the first edge with processor_enable=1 enters FETCH.
- control_unit inputs must be stable from EXECUTE through the end of STALL (the instruction register is held).

Decomposition:
- Shared package cpu_pkg:
  - state encoding constants SEQ_IDLE, SEQ_FETCH, SEQ_EXECUTE, SEQ_STALL;
  - opcode constants used by control_unit;
  - default LOAD_WAIT_CYCLES.
- No sub-module; the FSM, stall counter and retire counter live in one module.

Test Plan:
1. Hold reset=0 with processor_enable=1 → state=00, all strobes 0, retired_count=0. Release → state=01 after one edge, instruction_load=1.
2. R-type add (register_write_in=1, others 0), enable=1 → states 01,10,01,…; pc_write=1 and register_write=1 in EXECUTE only; retired_count=1 after 2 cycles, 5 after 10 cycles.
3. Load, LOAD_WAIT_CYCLES=1, register_write_in=1 → states 01,10,11. pc_write and register_write are 0 in EXECUTE and 1 in STALL. retired_count advances by 1 per 3 cycles.
4. Store (memory_write_in=1, register_write_in=0) → memory_write=1 for exactly one cycle (EXECUTE); register_write=0 throughout; retired_count+1.
5. Drop enable during a load's STALL → pc_write=1 in STALL, then state=00, count+1. Drop enable while in FETCH → next state 00, instruction_load=0, count unchanged.
6. Assert reset=0 mid-EXECUTE of a store → memory_write drops combinationally at once, retired_count=0, state=00. Separately, run 65536 R-type instructions from reset → retired_count returns to 0.
